// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the program counter, applies PC-select
// commands from the control unit, and fetches one 32-bit instruction word
// per request over a req/ack handshake into a registered IR.
module instr_fetch_unit #(
   parameter int                    ADDR_WIDTH = 64,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    TIMEOUT    = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  fetch_start,
   input  logic                  pc_update,
   input  logic [1:0]            PC_sel,
   input  logic [31:0]           k,
   input  logic [ADDR_WIDTH-1:0] pc_in,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic                  imem_req,
   input  logic                  imem_ack,
   input  logic [31:0]           imem_rdata,
   output logic [31:0]           IR,
   output logic                  ir_valid,
   output logic [ADDR_WIDTH-1:0] PC,
   output logic                  busy,
   output logic                  fault
);

   // Counter only needs to reach TIMEOUT-1; keep at least one bit.
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic [1:0] SEL_HOLD  = 2'b00;
   localparam logic [1:0] SEL_PLUS4 = 2'b01;
   localparam logic [1:0] SEL_JUMP  = 2'b10;
   localparam logic [1:0] SEL_IN    = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t                  state_q;
   logic [ADDR_WIDTH-1:0]   pc_q;
   logic [ADDR_WIDTH-1:0]   pc_d;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic                    req_q;
   logic [31:0]             ir_q;
   logic                    ir_valid_q;
   logic                    busy_q;
   logic                    fault_q;
   logic [CNT_W-1:0]        cnt_q;

   logic signed [31:0]            k_s;
   logic signed [ADDR_WIDTH-1:0]  jump_off;

   // Word offset sign-extended to address width and scaled to bytes; the
   // add below is modulo 2^ADDR_WIDTH so wrap-around is silent.
   assign k_s      = k;
   assign jump_off = ADDR_WIDTH'(k_s) <<< 2;

   // Next-PC selection; IN deliberately keeps the low bits so a misaligned
   // target is caught by the next fetch rather than silently corrected.
   always_comb begin
      pc_d = pc_q;
      if (pc_update) begin
         unique case (PC_sel)
            SEL_HOLD:  pc_d = pc_q;
            SEL_PLUS4: pc_d = pc_q + ADDR_WIDTH'(4);
            SEL_JUMP:  pc_d = pc_q + $unsigned(jump_off);
            SEL_IN:    pc_d = pc_in;
            default:   pc_d = pc_q;
         endcase
      end
   end

   // Program counter register, updated in any FSM state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   // Fetch FSM with registered handshake, IR and status outputs. A fetch
   // issued together with a PC update uses the pre-update pc_q.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= RESET_PC;
         req_q      <= 1'b0;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         fault_q    <= 1'b0;
         cnt_q      <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (fetch_start) begin
                  if (pc_q[1:0] == 2'b00) begin
                     addr_q     <= pc_q;
                     req_q      <= 1'b1;
                     ir_valid_q <= 1'b0;
                     fault_q    <= 1'b0;
                     cnt_q      <= '0;
                     busy_q     <= 1'b1;
                     state_q    <= ST_WAIT;
                  end else begin
                     fault_q    <= 1'b1;
                     ir_valid_q <= 1'b0;
                  end
               end
            end
            ST_WAIT: begin
               if (imem_ack) begin
                  ir_q       <= imem_rdata;
                  ir_valid_q <= 1'b1;
                  req_q      <= 1'b0;
                  busy_q     <= 1'b0;
                  state_q    <= ST_IDLE;
               end else if (cnt_q == CNT_LAST) begin
                  req_q      <= 1'b0;
                  fault_q    <= 1'b1;
                  ir_valid_q <= 1'b0;
                  busy_q     <= 1'b0;
                  state_q    <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               req_q   <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign imem_addr = addr_q;
   assign imem_req  = req_q;
   assign IR        = ir_q;
   assign ir_valid  = ir_valid_q;
   assign PC        = pc_q;
   assign busy      = busy_q;
   assign fault     = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: PC commands, fetch handshake,
// misaligned fault, timeout, same-cycle fetch/update and mid-WAIT reset.
module tb_instr_fetch_unit;

   logic        clock;
   logic        reset;
   logic        fetch_start;
   logic        pc_update;
   logic [1:0]  PC_sel;
   logic [31:0] k;
   logic [63:0] pc_in;
   logic [63:0] imem_addr;
   logic        imem_req;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] IR;
   logic        ir_valid;
   logic [63:0] PC;
   logic        busy;
   logic        fault;

   int checks   = 0;
   int failures = 0;

   instr_fetch_unit #(
      .ADDR_WIDTH (64),
      .RESET_PC   (64'd0),
      .TIMEOUT    (16)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .fetch_start (fetch_start),
      .pc_update   (pc_update),
      .PC_sel      (PC_sel),
      .k           (k),
      .pc_in       (pc_in),
      .imem_addr   (imem_addr),
      .imem_req    (imem_req),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .IR          (IR),
      .ir_valid    (ir_valid),
      .PC          (PC),
      .busy        (busy),
      .fault       (fault)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   initial begin
      reset       = 1'b0;
      fetch_start = 1'b0;
      pc_update   = 1'b0;
      PC_sel      = 2'b00;
      k           = 32'd0;
      pc_in       = 64'd0;
      imem_ack    = 1'b0;
      imem_rdata  = 32'd0;

      // Reset values
      #12;
      check("rst_pc",       PC,        64'd0);
      check("rst_addr",     imem_addr, 64'd0);
      check("rst_req",      imem_req,  64'd0);
      check("rst_ir",       IR,        64'd0);
      check("rst_ir_valid", ir_valid,  64'd0);
      check("rst_busy",     busy,      64'd0);
      check("rst_fault",    fault,     64'd0);
      reset = 1'b1;
      step();

      // Fetch at PC=0, ack on the 4th edge after the request
      imem_rdata  = 32'hD6000002;
      fetch_start = 1'b1;
      step();
      fetch_start = 1'b0;
      check("f1_req",  imem_req,  64'd1);
      check("f1_busy", busy,      64'd1);
      check("f1_addr", imem_addr, 64'd0);
      step(); step(); step();
      check("f1_req_hold",  imem_req, 64'd1);
      check("f1_vld_wait",  ir_valid, 64'd0);
      imem_ack = 1'b1;
      step();
      imem_ack = 1'b0;
      check("f1_ir",    IR,        64'hD6000002);
      check("f1_valid", ir_valid,  64'd1);
      check("f1_req_lo",imem_req,  64'd0);
      check("f1_busy_lo", busy,    64'd0);
      check("f1_pc",    PC,        64'd0);
      check("f1_fault", fault,     64'd0);

      // PLUS4 x3, JUMP -2, IN 0x100
      pc_update = 1'b1;
      PC_sel    = 2'b01;
      step();
      check("plus4_1", PC, 64'd4);
      step(); step();
      check("plus4_3", PC, 64'd12);
      PC_sel = 2'b10;
      k      = 32'hFFFF_FFFE;
      step();
      check("jump_m2", PC, 64'd4);
      PC_sel = 2'b11;
      pc_in  = 64'h100;
      step();
      check("in_100", PC, 64'h100);
      PC_sel = 2'b00;
      step();
      check("hold", PC, 64'h100);

      // Wrap-around
      PC_sel = 2'b11;
      pc_in  = 64'hFFFF_FFFF_FFFF_FFFC;
      step();
      PC_sel = 2'b01;
      step();
      check("wrap", PC, 64'd0);

      // Misaligned fetch
      PC_sel = 2'b11;
      pc_in  = 64'h102;
      step();
      pc_update   = 1'b0;
      fetch_start = 1'b1;
      step();
      fetch_start = 1'b0;
      check("mis_fault", fault,    64'd1);
      check("mis_req",   imem_req, 64'd0);
      check("mis_valid", ir_valid, 64'd0);
      check("mis_busy",  busy,     64'd0);
      step();
      check("mis_req2",  imem_req, 64'd0);
      check("mis_sticky",fault,    64'd1);

      // Aligned fetch clears fault; minimum-latency ack
      pc_update = 1'b1;
      PC_sel    = 2'b11;
      pc_in     = 64'h100;
      step();
      pc_update   = 1'b0;
      fetch_start = 1'b1;
      step();
      fetch_start = 1'b0;
      check("clr_fault", fault,     64'd0);
      check("clr_req",   imem_req,  64'd1);
      check("clr_addr",  imem_addr, 64'h100);
      imem_rdata = 32'h1234_5678;
      imem_ack   = 1'b1;
      step();
      imem_ack = 1'b0;
      check("min_ir",    IR,       64'h1234_5678);
      check("min_valid", ir_valid, 64'd1);

      // Timeout: no ack for 16 edges
      imem_rdata  = 32'hCAFE_F00D;
      fetch_start = 1'b1;
      step();
      fetch_start = 1'b0;
      for (int i = 0; i < 15; i++) step();
      check("to_req_15",   imem_req, 64'd1);
      check("to_fault_15", fault,    64'd0);
      step();
      check("to_req",   imem_req, 64'd0);
      check("to_fault", fault,    64'd1);
      check("to_valid", ir_valid, 64'd0);
      check("to_busy",  busy,     64'd0);
      check("to_ir",    IR,       64'h1234_5678);

      // Ack in IDLE is ignored
      imem_rdata = 32'hDEAD_BEEF;
      imem_ack   = 1'b1;
      step();
      imem_ack = 1'b0;
      check("idle_ack_ir",    IR,       64'h1234_5678);
      check("idle_ack_valid", ir_valid, 64'd0);

      // Same-cycle fetch + PLUS4 at PC=8, then JUMP during WAIT
      pc_update = 1'b1;
      PC_sel    = 2'b11;
      pc_in     = 64'd8;
      step();
      PC_sel      = 2'b01;
      fetch_start = 1'b1;
      step();
      fetch_start = 1'b0;
      check("same_addr", imem_addr, 64'd8);
      check("same_pc",   PC,        64'd12);
      check("same_req",  imem_req,  64'd1);
      PC_sel = 2'b10;
      k      = 32'd3;
      step();
      pc_update = 1'b0;
      check("wjump_addr", imem_addr, 64'd8);
      check("wjump_pc",   PC,        64'd24);
      check("wjump_req",  imem_req,  64'd1);

      // Asynchronous reset mid-WAIT
      #2;
      reset = 1'b0;
      #1;
      check("arst_req",   imem_req,  64'd0);
      check("arst_busy",  busy,      64'd0);
      check("arst_pc",    PC,        64'd0);
      check("arst_addr",  imem_addr, 64'd0);
      check("arst_ir",    IR,        64'd0);
      check("arst_valid", ir_valid,  64'd0);
      check("arst_fault", fault,     64'd0);
      #10;
      reset = 1'b1;
      step();
      check("post_rst_req", imem_req, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
